// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: program load port, instruction store, PC register and
// combinational instruction presentation for the single-cycle datapath.
module instr_fetch_unit #(
  parameter int unsigned Depth    = 16,
  parameter int unsigned AddrW    = 4,
  parameter logic [31:0] HaltWord = 32'hFFFF_FFFF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_valid_i,
  input  logic [31:0]      load_data_i,
  input  logic             load_last_i,
  output logic             load_ready_o,
  input  logic             pc_src_i,
  input  logic [31:0]      branch_target_i,
  input  logic             stall_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic [31:0]      pc_plus8_o,
  output logic [31:0]      instr_o,
  output logic             instr_valid_o,
  output logic             halted_o,
  output logic [AddrW:0]   word_count_o
);

  typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [AddrW:0]   word_count_q, word_count_d;
  logic [31:0]      mem_q [Depth];
  logic             mem_we;
  logic [31:0]      mem_rdata;
  logic             aligned, in_range, not_halt, fetch_ok;

  // Asynchronous store read at the current PC; range is checked on the full PC, not the index.
  assign mem_rdata = mem_q[pc_q[AddrW+1:2]];
  assign aligned   = (pc_q[1:0] == 2'b00);
  assign in_range  = ((pc_q >> 2) < 32'(word_count_q));
  assign not_halt  = (mem_rdata != HaltWord);
  assign fetch_ok  = (state_q == StRun) && aligned && in_range && not_halt;

  // Next-state logic for the LOAD -> RUN -> HALT sequence, PC and word counter.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    word_count_d = word_count_q;
    mem_we       = 1'b0;
    case (state_q)
      StLoad: begin
        if (load_valid_i) begin
          mem_we       = 1'b1;
          word_count_d = word_count_q + 1'b1;
          if (load_last_i || (word_count_q == (AddrW+1)'(Depth - 1))) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!fetch_ok) begin
          state_d = StHalt;
        end else if (!stall_i) begin
          pc_d = pc_src_i ? branch_target_i : pc_q + 32'd4;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // State registers with synchronous reset; reset wins over every other input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StLoad;
      pc_q         <= 32'd0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      word_count_q <= word_count_d;
    end
  end

  // Instruction store write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i) begin
      mem_q[word_count_q[AddrW-1:0]] <= load_data_i;
    end
  end

  assign load_ready_o  = (state_q == StLoad);
  assign halted_o      = (state_q == StHalt);
  assign instr_valid_o = fetch_ok;
  assign instr_o       = fetch_ok ? mem_rdata : 32'd0;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign pc_plus8_o    = pc_q + 32'd8;
  assign word_count_o  = word_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized programs,
// all compared every cycle against a behavioural program/PC model.
module tb_instr_fetch_unit;

  localparam logic [31:0] Halt = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, load_valid, load_last, load_ready;
  logic [31:0] load_data;
  logic        pc_src, stall;
  logic [31:0] branch_target;
  logic [31:0] pc, pc_plus4, pc_plus8, instr;
  logic        instr_valid, halted;
  logic [4:0]  word_count;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .Depth    (16),
    .AddrW    (4),
    .HaltWord (Halt)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .load_valid_i    (load_valid),
    .load_data_i     (load_data),
    .load_last_i     (load_last),
    .load_ready_o    (load_ready),
    .pc_src_i        (pc_src),
    .branch_target_i (branch_target),
    .stall_i         (stall),
    .pc_o            (pc),
    .pc_plus4_o      (pc_plus4),
    .pc_plus8_o      (pc_plus8),
    .instr_o         (instr),
    .instr_valid_o   (instr_valid),
    .halted_o        (halted),
    .word_count_o    (word_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: phase 0=loading, 1=running, 2=halted.
  int unsigned m_phase;
  logic [31:0] m_pc;
  int unsigned m_count;
  logic [31:0] m_mem [16];
  bit          m_known = 1'b0;

  function automatic bit model_valid();
    logic [31:0] idx;
    idx = m_pc / 4;
    if (m_phase != 1) return 1'b0;
    if (m_pc % 4 != 0) return 1'b0;
    if (idx >= m_count) return 1'b0;
    return m_mem[idx[3:0]] != Halt;
  endfunction

  task automatic compare_outputs();
    logic [31:0] idx;
    logic [31:0] exp_instr;
    bit ok;
    idx       = m_pc / 4;
    ok        = model_valid();
    exp_instr = ok ? m_mem[idx[3:0]] : 32'd0;
    check_eq("pc", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("pc_plus8", pc_plus8, m_pc + 32'd8);
    check_eq("instr", instr, exp_instr);
    check_eq("instr_valid", 32'(instr_valid), 32'(ok));
    check_eq("load_ready", 32'(load_ready), 32'(m_phase == 0));
    check_eq("halted", 32'(halted), 32'(m_phase == 2));
    check_eq("word_count", 32'(word_count), m_count);
  endtask

  // One clock: drive after negedge, check before posedge, advance the model after posedge.
  task automatic cycle(input bit rst, input bit lv, input bit ll, input logic [31:0] ld,
                       input bit ps, input logic [31:0] bt, input bit st);
    bit ok;
    @(negedge clk);
    reset = rst; load_valid = lv; load_last = ll; load_data = ld;
    pc_src = ps; branch_target = bt; stall = st;
    #1;
    if (m_known) compare_outputs();
    ok = model_valid();
    @(posedge clk);
    #1;
    if (rst) begin
      m_phase = 0; m_pc = 32'd0; m_count = 0; m_known = 1'b1;
    end else if (m_known) begin
      if (m_phase == 0) begin
        if (lv) begin
          m_mem[m_count] = ld;
          m_count++;
          if (ll || m_count == 16) m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!ok) m_phase = 2;
        else if (!st) m_pc = ps ? bt : m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask
  task automatic load(input logic [31:0] w, input bit last);
    cycle(1'b0, 1'b1, last, w, 1'b0, 32'd0, 1'b0);
  endtask
  task automatic run(input bit ps, input logic [31:0] bt, input bit st);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, ps, bt, st);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == Halt) w = 32'h1234_5678;
    return w;
  endfunction

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = 32'd0;
    pc_src = 1'b0; branch_target = 32'd0; stall = 1'b0;

    // Reset state.
    do_reset();
    do_reset();
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    check_eq("rst_load_ready", 32'(load_ready), 32'd1);

    // Three-word program with an idle gap, runs off the end at PC=12.
    load(32'hA0A0_0001, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
    load(32'hB0B0_0002, 1'b0);
    load(32'hC0C0_0003, 1'b1);
    check_eq("abc_word_count", 32'(word_count), 32'd3);
    check_eq("abc_instr0", instr, 32'hA0A0_0001);
    for (int i = 0; i < 5; i++) run(1'b0, 32'd0, 1'b0);
    check_eq("abc_halt_pc", pc, 32'd12);
    check_eq("abc_halted", 32'(halted), 32'd1);

    // Full store without LoadLast; LoadValid ignored afterwards.
    do_reset();
    for (int i = 0; i < 16; i++) load(rand_word(), 1'b0);
    check_eq("full_load_ready", 32'(load_ready), 32'd0);
    check_eq("full_word_count", 32'(word_count), 32'd16);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, rand_word(), 1'b0, 32'd0, i[0]);
    check_eq("full_count_held", 32'(word_count), 32'd16);

    // Halt word at index 2.
    do_reset();
    load(32'h1111_0000, 1'b0);
    load(32'h2222_0000, 1'b0);
    load(Halt, 1'b0);
    load(32'h4444_0000, 1'b1);
    run(1'b0, 32'd0, 1'b0);
    run(1'b0, 32'd0, 1'b0);
    check_eq("hw_instr", instr, 32'd0);
    check_eq("hw_valid", 32'(instr_valid), 32'd0);
    run(1'b0, 32'd0, 1'b0);
    check_eq("hw_halted", 32'(halted), 32'd1);
    check_eq("hw_pc", pc, 32'd8);

    // Stall beats branch, then branch back, then misaligned branch.
    do_reset();
    for (int i = 0; i < 5; i++) load(rand_word(), i == 4);
    run(1'b0, 32'd0, 1'b0);
    run(1'b0, 32'd0, 1'b0);
    run(1'b1, 32'd0, 1'b1);
    check_eq("stall_pc", pc, 32'd8);
    run(1'b1, 32'd0, 1'b0);
    check_eq("branch_pc", pc, 32'd0);
    run(1'b1, 32'h6, 1'b0);
    check_eq("mis_pc", pc, 32'd6);
    run(1'b0, 32'd0, 1'b0);
    check_eq("mis_halted", 32'(halted), 32'd1);

    // Reset mid-load, then reload from index 0.
    do_reset();
    load(32'hAAAA_0000, 1'b0);
    load(32'hBBBB_0000, 1'b0);
    do_reset();
    check_eq("reload_count", 32'(word_count), 32'd0);
    check_eq("reload_ready", 32'(load_ready), 32'd1);
    for (int i = 0; i < 5; i++) load(32'h5000_0000 + 32'(i), i == 4);
    check_eq("reload_instr0", instr, 32'h5000_0000);
    for (int i = 0; i < 7; i++) run(1'b0, 32'd0, 1'b0);

    // Randomized programs.
    for (int p = 0; p < 40; p++) begin
      int unsigned n;
      n = $urandom_range(1, 16);
      do_reset();
      for (int i = 0; i < int'(n); i++) begin
        logic [31:0] w;
        while ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 1'b1, rand_word(), 1'b0, 32'd0, 1'b0);
        w = ($urandom_range(0, 19) == 0) ? Halt : rand_word();
        if ($urandom_range(0, 39) == 0) do_reset();
        load(w, (i == int'(n) - 1) && ($urandom_range(0, 3) != 0));
      end
      for (int c = 0; c < 40; c++) begin
        logic [31:0] bt;
        if ($urandom_range(0, 9) == 0) bt = $urandom_range(0, 80);
        else bt = 32'($urandom_range(0, n)) * 32'd4;
        cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 1'b0, rand_word(),
              $urandom_range(0, 3) == 0, bt, $urandom_range(0, 4) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
